// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receiver: FSM states, status bit positions, word addresses.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int STAT_VALID   = 31;
    localparam int STAT_OVERRUN = 30;
    localparam int STAT_FRAMERR = 29;

    localparam logic ADDR_DATA  = 1'b0;
    localparam logic ADDR_COUNT = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset level.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            q_reg    <= RESET_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/serialrx.sv
// serialrx: 8N1-style UART receiver with mid-bit sampling, a one-entry holding register and a Wishbone slave.
// Define SERIALRX_COUNT_EN to build the 32-bit received-frame counter readable at word 1.
module serialrx
    import serial_pkg::*;
#(
    parameter int DIVIDE = 2,
    parameter int FRAME  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data_w,
    output logic [31:0] wb_data_r,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        wb_stall
);
    localparam int DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int BW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIVIDE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);

    if (DIVIDE < 2) begin : g_bad_divide
        $error("serialrx: DIVIDE must be >= 2");
    end
    if (FRAME > 29) begin : g_bad_frame
        $error("serialrx: FRAME must be <= 29");
    end

    logic rx_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rx),
        .q   (rx_s)
    );

    rx_state_t        state_reg, state_next;
    logic [DW-1:0]    div_reg, div_next;
    logic [BW-1:0]    bit_idx_reg, bit_idx_next;
    logic [FRAME-1:0] shift_reg, shift_next;
    logic             deliver;
    logic             ferr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        deliver      = 1'b0;
        ferr_set     = 1'b0;
        case (state_reg)
            IDLE: begin
                div_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                // Half a bit in: a line that has gone high again was only a glitch.
                if (div_reg == DIV_HALF) begin
                    div_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (div_reg == DIV_LAST) begin
                    div_next                = '0;
                    shift_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == BIT_LAST) state_next = STOP;
                    else bit_idx_next = bit_idx_reg + 1'b1;
                end
            end
            STOP: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (rx_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                div_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic req, is_count, rd_clear, wr_data, wr_count;
    assign req      = wb_stb & wb_cyc;
    assign is_count = (wb_addr[2] == ADDR_COUNT);
    assign rd_clear = req & ~wb_we & ~is_count;
    assign wr_data  = req &  wb_we & ~is_count;
    assign wr_count = req &  wb_we &  is_count;

    logic             valid_reg, overrun_reg, ferr_reg;
    logic [FRAME-1:0] data_reg;

    // Sets are written after clears so a coincident set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            ferr_reg    <= 1'b0;
            data_reg    <= '0;
        end else begin
            if (rd_clear) valid_reg <= 1'b0;
            if (wr_data && wb_data_w[STAT_OVERRUN]) overrun_reg <= 1'b0;
            if (wr_data && wb_data_w[STAT_FRAMERR]) ferr_reg <= 1'b0;
            if (deliver) begin
                if (!valid_reg || rd_clear) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
            if (ferr_set) ferr_reg <= 1'b1;
        end
    end

    logic [31:0] count_value;

`ifdef SERIALRX_COUNT_EN
    logic [31:0] num_bytes_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            num_bytes_reg <= '0;
        end else begin
            if (wr_count) num_bytes_reg <= '0;
            if (deliver) num_bytes_reg <= (wr_count ? 32'd0 : num_bytes_reg) + 32'd1;
        end
    end

    assign count_value = num_bytes_reg;
`else
    logic unused_wr_count;
    assign unused_wr_count = wr_count;
    assign count_value     = '0;
`endif

    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (is_count) begin
            rd_word = count_value;
        end else begin
            rd_word[FRAME-1:0]   = data_reg;
            rd_word[STAT_VALID]   = valid_reg;
            rd_word[STAT_OVERRUN] = overrun_reg;
            rd_word[STAT_FRAMERR] = ferr_reg;
        end
    end

    logic        ack_reg;
    logic [31:0] data_r_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg    <= 1'b0;
            data_r_reg <= '0;
        end else begin
            ack_reg    <= req;
            data_r_reg <= (req && !wb_we) ? rd_word : 32'd0;
        end
    end

    assign wb_ack    = ack_reg;
    assign wb_data_r = data_r_reg;
    assign wb_stall  = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wb_addr[31:3], wb_addr[1:0], wb_data_w[31], wb_data_w[28:0]};

endmodule

// File: tb/tb_serialrx.sv
// Self-checking bench for serialrx (DIVIDE=4, FRAME=8): directed vector table, hand-written corner sequences
// and randomized traffic checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_serialrx;
    localparam int D = 4;
`ifdef SERIALRX_COUNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data_w = '0;
    logic [31:0] wb_data_r;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic        wb_stall;

    always #5 clk = ~clk;

    serialrx #(.DIVIDE(D), .FRAME(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .wb_addr   (wb_addr),
        .wb_data_w (wb_data_w),
        .wb_data_r (wb_data_r),
        .wb_we     (wb_we),
        .wb_stb    (wb_stb),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the receiver's visible state at frame granularity.
    logic       m_valid, m_over, m_ferr;
    logic [7:0] m_data;
    int unsigned m_count;

    typedef enum int {OP_RESET, OP_FRAME, OP_BAD, OP_GLITCH, OP_READ, OP_WRITE} op_t;
    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input op_t op, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One bus transaction; stb is presented for one cycle and ack is required one cycle later.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data_w = wdata;
        @(posedge clk); #1;
        check("ack_latency", {31'd0, wb_ack}, 32'd1);
        rdata = wb_data_r;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        $display("bus %s addr=%08h wdata=%08h rdata=%08h ack=%0d", we ? "wr" : "rd", addr, wdata, rdata, wb_ack);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] r;
        bus(1'b0, addr, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        bus(1'b1, addr, data, r);
    endtask

    // Caller is #1 after a rising edge; each bit is held for exactly D clocks.
    task automatic drive_bits(input logic [7:0] b, input bit good);
        logic [9:0] bits;
        bits = {good, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (D) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        @(posedge clk); #1;
        drive_bits(b, good);
        repeat (8) @(posedge clk);
        $display("line frame=%02h stop=%0d", b, good);
    endtask

    task automatic glitch();
        @(posedge clk); #1 uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (8) @(posedge clk);
        $display("line glitch");
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0; m_data = 8'h00; m_count = 0;
        $display("reset");
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (good) begin
            m_count++;
            if (m_valid) m_over = 1'b1;
            else begin
                m_data  = b;
                m_valid = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [31:0] w;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, wb_ack}, 32'd0);
        check("reset_data_r", wb_data_r, 32'd0);
        check("reset_stall", {31'd0, wb_stall}, 32'd0);
        rst = 1'b0;
        do_read(32'h0, 32'h0, "reset_word0");
        do_read(32'h4, 32'h0, "reset_word1");

        // Directed vector table.
        add(OP_FRAME,  0, 32'hA5, 0);
        add(OP_READ,   0, 0, 32'h800000A5);
        add(OP_READ,   0, 0, 32'h000000A5);
        add(OP_GLITCH, 0, 0, 0);
        add(OP_READ,   0, 0, 32'h000000A5);
        add(OP_RESET,  0, 0, 0);
        add(OP_BAD,    0, 32'h3C, 0);
        add(OP_READ,   0, 0, 32'h20000000);
        add(OP_WRITE,  0, 32'h20000000, 0);
        add(OP_READ,   0, 0, 32'h00000000);
        add(OP_FRAME,  0, 32'h11, 0);
        add(OP_FRAME,  0, 32'h22, 0);
        add(OP_READ,   0, 0, 32'hC0000011);
        add(OP_READ,   4, 0, HAS_CNT ? 32'd2 : 32'd0);
        add(OP_READ,   0, 0, 32'h40000011);
        add(OP_WRITE,  0, 32'h40000000, 0);
        add(OP_READ,   0, 0, 32'h00000011);
        add(OP_WRITE,  4, 0, 0);
        add(OP_READ,   4, 0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_RESET:  do_reset();
                OP_FRAME:  send_frame(vecs[i].data[7:0], 1'b1);
                OP_BAD:    send_frame(vecs[i].data[7:0], 1'b0);
                OP_GLITCH: glitch();
                OP_READ:   do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_read", i));
                OP_WRITE:  do_write(vecs[i].addr, vecs[i].data);
                default:   ;
            endcase
        end

        // Frame delivered on the same edge as a clearing read's ack.
        do_reset();
        send_frame(8'h33, 1'b1);
        @(posedge clk); #1;
        fork
            drive_bits(8'h5A, 1'b1);
            begin
                repeat (39) @(posedge clk);
                bus(1'b0, 32'h0, 32'd0, r);
                check("coincide_old", r, 32'h80000033);
            end
        join
        repeat (8) @(posedge clk);
        do_read(32'h0, 32'h8000005A, "coincide_new");
        @(posedge clk); #1;
        check("ack_drop", {31'd0, wb_ack}, 32'd0);
        do_read(32'h0, 32'h0000005A, "coincide_cleared");

        // Strobe without cycle: no ack, valid untouched.
        send_frame(8'h77, 1'b1);
        @(posedge clk); #1;
        wb_stb = 1'b1; wb_cyc = 1'b0; wb_addr = 32'h0;
        @(posedge clk); #1;
        check("no_cyc_ack", {31'd0, wb_ack}, 32'd0);
        wb_stb = 1'b0;
        do_read(32'h0, 32'h80000077, "no_cyc_valid_kept");

        // Reset held from the middle of frame 0x55 until its end, then 0x0F.
        do_reset();
        @(posedge clk); #1;
        fork
            drive_bits(8'h55, 1'b1);
            begin
                repeat (4 * D + 2) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        send_frame(8'h0F, 1'b1);
        do_read(32'h0, 32'h8000000F, "rst_mid_word0");
        do_read(32'h4, HAS_CNT ? 32'd1 : 32'd0, "rst_mid_count");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0, 1: begin
                    b = 8'($urandom);
                    send_frame(b, 1'b1);
                    model_frame(b, 1'b1);
                end
                2: begin
                    b = 8'($urandom);
                    send_frame(b, 1'b0);
                    model_frame(b, 1'b0);
                end
                3: glitch();
                4: begin
                    do_read(32'h0, {m_valid, m_over, m_ferr, 21'd0, m_data}, $sformatf("rand%0d_word0", i));
                    m_valid = 1'b0;
                end
                5: do_read(32'h4, HAS_CNT ? m_count : 32'd0, $sformatf("rand%0d_word1", i));
                6: begin
                    w = $urandom;
                    do_write(32'h0, w);
                    if (w[30]) m_over = 1'b0;
                    if (w[29]) m_ferr = 1'b0;
                end
                default: begin
                    do_write(32'h4, $urandom);
                    m_count = 0;
                end
            endcase
        end
        do_read(32'h0, {m_valid, m_over, m_ferr, 21'd0, m_data}, "rand_final_word0");
        do_read(32'h4, HAS_CNT ? m_count : 32'd0, "rand_final_word1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
